truth_table_sequencer: RTL

TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

---
 rtl/truth_table_sequencer_if.sv | 28 ++
 rtl/truth_table_sequencer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/truth_table_sequencer_if.sv
// Stimulus/response bundle between the truth-table sequencer and the DUT/model pair.
// master = sequencer side, slave = DUT/model/observer side.
interface truth_table_sequencer_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2
);
  logic              start;
  logic              gray;
  logic [N_OUT-1:0]  dut_out;
  logic [N_OUT-1:0]  exp_out;
  logic [N_IN-1:0]   vec_out;
  logic              busy;
  logic              done;
  logic              pass;
  logic [N_IN:0]     err_count;
  logic              first_err_valid;
  logic [N_IN-1:0]   first_err_vec;

  modport master (
    input  start, gray, dut_out, exp_out,
    output vec_out, busy, done, pass, err_count, first_err_valid, first_err_vec
  );

  modport slave (
    output start, gray, dut_out, exp_out,
    input  vec_out, busy, done, pass, err_count, first_err_valid, first_err_vec
  );
endinterface

// File: rtl/truth_table_sequencer.sv
// Exhaustive truth-table checker: sweeps every N_IN-bit vector (binary or Gray order),
// holds each HOLD cycles, compares DUT vs model; a run takes 2^N_IN*HOLD cycles, start ignored while busy.
module truth_table_sequencer #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2,
  parameter int HOLD  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  truth_table_sequencer_if.master       bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam int             CW        = N_IN + 1;
  localparam logic [CW-1:0]  LAST_IDX  = CW'((1 << N_IN) - 1);
  localparam logic [CW-1:0]  ERR_MAX   = CW'(1 << N_IN);
  localparam logic [15:0]    HOLD_LAST = 16'(HOLD - 1);

  state_t            state, state_nxt;
  logic [CW-1:0]     idx;
  logic [CW-1:0]     idx_nxt;
  logic [15:0]       hold_cnt;
  logic              mode;
  logic [N_IN-1:0]   vec_q;
  logic              busy_q, done_q, pass_q;
  logic [CW-1:0]     err_q;
  logic              fev_q;
  logic [N_IN-1:0]   fevec_q;

  logic              start_run;
  logic              check_edge;
  logic              last_vec;
  logic              mismatch;

  function automatic logic [N_IN-1:0] map_vec(input logic [CW-1:0] i, input logic g);
    logic [CW-1:0] v;
    v = g ? (i ^ (i >> 1)) : i;
    return v[N_IN-1:0];
  endfunction

  assign mismatch = (bus.dut_out != bus.exp_out);
  assign idx_nxt  = idx + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start_run  = 1'b0;
    check_edge = 1'b0;
    last_vec   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          start_run = 1'b1;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        check_edge = (hold_cnt == HOLD_LAST);
        last_vec   = check_edge && (idx == LAST_IDX);
        if (last_vec) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Start is only decoded outside DRIVE, so a mid-run pulse cannot reach this datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      hold_cnt <= '0;
      mode     <= 1'b0;
      vec_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fev_q    <= 1'b0;
      fevec_q  <= '0;
    end else if (start_run) begin
      idx      <= '0;
      hold_cnt <= '0;
      mode     <= bus.gray;
      vec_q    <= map_vec('0, bus.gray);
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fev_q    <= 1'b0;
      fevec_q  <= '0;
    end else if (state == DRIVE) begin
      if (check_edge) begin
        hold_cnt <= '0;
        if (mismatch) begin
          if (err_q != ERR_MAX) err_q <= err_q + CW'(1);
          if (!fev_q) begin
            fev_q   <= 1'b1;
            fevec_q <= vec_q;
          end
        end
        if (last_vec) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          pass_q <= (err_q == '0) && !mismatch;
        end else begin
          idx   <= idx_nxt;
          vec_q <= map_vec(idx_nxt, mode);
        end
      end else begin
        hold_cnt <= hold_cnt + 16'd1;
      end
    end
  end

  assign bus.vec_out         = vec_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.err_count       = err_q;
  assign bus.first_err_valid = fev_q;
  assign bus.first_err_vec   = fevec_q;

endmodule
